key_ctrl: RTL and testbench
===========================

Name: key_ctrl

Overview:
- Control stage between the PS/2 keyboard decoder and the game datapath (slime mover, floor generator, display mux).
- Owns the COVER/PLAY/OVER game FSM.
- Converts raw key make/break events into a one-cycle start pulse and rate-limited left/right step pulses.
- Arbitrates A and D when both keys are held.

Parameters:
- REPEAT_CYCLES, 2500000, clk cycles between repeated step pulses while a direction is held (40 Hz at 100 MHz).
- OVER_CYCLES, 50000000, clk cycles spent in OVER before returning to COVER (0.5 s at 100 MHz).
- CNT_W, 26, counter width; must hold max(REPEAT_CYCLES, OVER_CYCLES).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset (0 = reset)
- key_valid  in  1  one-cycle strobe from decoder: last_change/key_down updated
- last_change  in  9  scan code of latest event; bit 8 = extended (E0) prefix
- key_down  in  512  per-scan-code held flags from decoder
- slime_die  in  1  level from slime mover; death detected
- game_state  out  2  0 = COVER, 1 = PLAY, 2 = OVER
- start_pulse  out  1  one-cycle pulse on entering PLAY
- key_state  out  2  step pulse: 2'b10 = left, 2'b01 = right, 2'b00 = none
- rst_game  out  1  active-high game-datapath reset; high in COVER and OVER, low in PLAY

Behaviour:
- Reset (rst = 0, asynchronous):
  - game_state = COVER, start_pulse = 0, key_state = 00, rst_game = 1.
  - Counters cleared; last_dir = none.
- Press event: key_valid && key_down[last_change]. Release event: key_valid && !key_down[last_change].
- Enter: last_change == 9'h05A or 9'h15A. A: 9'h01C. D: 9'h023. No other codes are recognised.
- FSM, all transitions registered:
  - COVER -> PLAY on an Enter press event. start_pulse = 1 in the first PLAY cycle only. rst_game drops in that same cycle.
  - PLAY -> OVER when slime_die = 1; sampled every PLAY cycle, including the first.
  - OVER: over_cnt counts 0..OVER_CYCLES-1, then the FSM goes to COVER on the next cycle. over_cnt is cleared on entry.
  - All key events are ignored in OVER.
  - An Enter press in PLAY or OVER has no effect.
  - Encoding 2'd3 is unreachable; if ever entered, go to COVER on the next cycle.
- Direction (evaluated only in PLAY; key_state forced to 00 in other states):
  - hold_a = key_down[9'h01C], hold_d = key_down[9'h023].
  - last_dir is updated on A or D press events only. It is cleared on entering PLAY.
  - dir = A if only hold_a; D if only hold_d; last_dir if both are held; none otherwise.
- Step pulse:
  - When dir changes to a non-none value, key_state pulses for 1 cycle in the cycle after the change. rep_cnt is cleared.
  - While dir is unchanged and non-none, rep_cnt increments each cycle. When rep_cnt reaches REPEAT_CYCLES-1, key_state pulses 1 cycle and rep_cnt wraps to 0.
  - dir = none: rep_cnt held at 0, no pulse.
  - Switching A to D directly: immediate D pulse, counter restarts.
- Simultaneous events:
  - slime_die and a direction pulse in the same cycle: the transition wins and key_state = 00.
  - Enter press and slime_die in COVER: Enter wins (slime_die is ignored outside PLAY).
- Counters saturate-free: rep_cnt and over_cnt use CNT_W bits; parameter values must be >= 1.
- Reset mid-PLAY or mid-OVER: immediately COVER, all outputs return to reset values.
- Latency: input event to output is 1 clk.

Test Plan:
- Reset release, no keys -> game_state = 0, rst_game = 1, key_state = 00 for 100 cycles.
- In COVER: key_valid with last_change = 9'h15A and key_down[346] = 1 -> next cycle game_state = 1, start_pulse high exactly 1 cycle, rst_game = 0.
- In PLAY, REPEAT_CYCLES = 8: press A held for 20 cycles -> key_state = 10 one cycle after press, then at +8 and +16, then stops on release.
- In PLAY: hold A, then press D while A is still held -> key_state = 01 next cycle. Release D with A still held -> key_state = 10 next cycle.
- In PLAY, OVER_CYCLES = 10: slime_die pulse -> game_state = 2 next cycle, key_state = 00. An Enter press during OVER is ignored. game_state = 0 after 10 OVER cycles.
- Mid-OVER: assert rst = 0 for 1 cycle asynchronously -> outputs at reset values immediately. After release the FSM stays in COVER.

Source files
------------

// File: rtl/key_ctrl.sv
// key_ctrl: game-mode FSM (COVER/PLAY/OVER) plus key event handling.
// Turns decoder make/break events into a start pulse and rate-limited
// left/right step pulses. When A and D are both held, the most recently
// pressed of the two wins.
module key_ctrl #(
  parameter int unsigned REPEAT_CYCLES = 2500000,
  parameter int unsigned OVER_CYCLES   = 50000000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  input  logic         slime_die,
  output logic [1:0]   game_state,
  output logic         start_pulse,
  output logic [1:0]   key_state,
  output logic         rst_game
);

  typedef enum logic [1:0] {
    COVER = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_e;

  // Each direction is encoded as its step-pulse pattern, so a pulse drives key_state directly.
  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_A    = 2'b10,
    DIR_D    = 2'b01
  } dir_e;

  localparam logic [8:0] CODE_ENTER   = 9'h05A;
  localparam logic [8:0] CODE_ENTER_E = 9'h15A;
  localparam logic [8:0] CODE_A       = 9'h01C;
  localparam logic [8:0] CODE_D       = 9'h023;

  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] OVER_LAST = CNT_W'(OVER_CYCLES - 1);

  state_e           state_q, state_d;
  dir_e             last_dir_q, last_dir_d;
  dir_e             prev_dir_q, prev_dir_d;
  dir_e             key_state_q, key_state_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [CNT_W-1:0] over_cnt_q, over_cnt_d;
  logic             start_q, start_d;
  logic             rst_game_q, rst_game_d;

  logic press, enter_press, a_press, d_press;
  logic hold_a, hold_d;
  dir_e last_dir_now;
  dir_e dir;

  // Decode events, pick the active direction, and compute next state and outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    last_dir_d  = last_dir_q;
    prev_dir_d  = prev_dir_q;
    rep_cnt_d   = rep_cnt_q;
    over_cnt_d  = over_cnt_q;
    key_state_d = DIR_NONE;

    press       = key_valid && key_down[last_change];
    enter_press = press && ((last_change == CODE_ENTER) || (last_change == CODE_ENTER_E));
    a_press     = press && (last_change == CODE_A);
    d_press     = press && (last_change == CODE_D);
    hold_a      = key_down[CODE_A];
    hold_d      = key_down[CODE_D];

    // A press arriving this cycle already decides an A+D tie this cycle.
    if (a_press)      last_dir_now = DIR_A;
    else if (d_press) last_dir_now = DIR_D;
    else              last_dir_now = last_dir_q;

    if (hold_a && !hold_d)      dir = DIR_A;
    else if (hold_d && !hold_a) dir = DIR_D;
    else if (hold_a && hold_d)  dir = last_dir_now;
    else                        dir = DIR_NONE;

    case (state_q)
      COVER: begin
        last_dir_d = DIR_NONE;
        prev_dir_d = DIR_NONE;
        rep_cnt_d  = '0;
        over_cnt_d = '0;
        if (enter_press) state_d = PLAY;
      end
      PLAY: begin
        last_dir_d = last_dir_now;
        prev_dir_d = dir;
        if (dir == DIR_NONE) begin
          rep_cnt_d = '0;
        end else if (dir != prev_dir_q) begin
          rep_cnt_d   = '0;
          key_state_d = dir;
        end else if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d   = '0;
          key_state_d = dir;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
        // Death takes priority over a step pulse in the same cycle.
        if (slime_die) begin
          state_d     = OVER;
          over_cnt_d  = '0;
          key_state_d = DIR_NONE;
        end
      end
      OVER: begin
        last_dir_d = DIR_NONE;
        prev_dir_d = DIR_NONE;
        rep_cnt_d  = '0;
        if (over_cnt_q == OVER_LAST) begin
          state_d    = COVER;
          over_cnt_d = '0;
        end else begin
          over_cnt_d = over_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = COVER;
        last_dir_d = DIR_NONE;
        prev_dir_d = DIR_NONE;
        rep_cnt_d  = '0;
        over_cnt_d = '0;
      end
    endcase

    start_d    = (state_q == COVER) && enter_press;
    rst_game_d = (state_d != PLAY);
  end

  // State, counters and registered outputs; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= COVER;
      last_dir_q  <= DIR_NONE;
      prev_dir_q  <= DIR_NONE;
      key_state_q <= DIR_NONE;
      rep_cnt_q   <= '0;
      over_cnt_q  <= '0;
      start_q     <= 1'b0;
      rst_game_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      prev_dir_q  <= prev_dir_d;
      key_state_q <= key_state_d;
      rep_cnt_q   <= rep_cnt_d;
      over_cnt_q  <= over_cnt_d;
      start_q     <= start_d;
      rst_game_q  <= rst_game_d;
    end
  end

  assign game_state  = state_q;
  assign start_pulse = start_q;
  assign key_state   = key_state_q;
  assign rst_game    = rst_game_q;

endmodule

// File: tb/tb_key_ctrl.sv
// Testbench for key_ctrl: directed scenarios followed by random key/death
// traffic, all checked every cycle against a behavioural model.
module tb_key_ctrl;

  localparam int R = 8;
  localparam int O = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic         slime_die;
  logic [1:0]   game_state;
  logic         start_pulse;
  logic [1:0]   key_state;
  logic         rst_game;

  key_ctrl #(
    .REPEAT_CYCLES(R),
    .OVER_CYCLES  (O),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .last_change(last_change),
    .key_down   (key_down),
    .slime_die  (slime_die),
    .game_state (game_state),
    .start_pulse(start_pulse),
    .key_state  (key_state),
    .rst_game   (rst_game)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0/1/2, direction 0 none / 1 A / 2 D,
  // age = cycles the current direction has been held unchanged.
  int         m_mode, m_spent, m_last, m_prev, m_age;
  logic [1:0] e_gs, e_ks;
  logic       e_start, e_rg;

  task automatic model_reset();
    m_mode = 0; m_spent = 0; m_last = 0; m_prev = 0; m_age = 0;
    e_gs = 2'd0; e_ks = 2'b00; e_start = 1'b0; e_rg = 1'b1;
  endtask

  // Expected outputs after the coming edge, from the inputs now driven.
  task automatic model_step();
    logic press;
    int   d;
    press   = key_valid && key_down[last_change];
    e_start = 1'b0;
    e_ks    = 2'b00;
    if (m_mode == 0) begin
      if (press && (last_change == 9'h05A || last_change == 9'h15A)) begin
        m_mode = 1; e_start = 1'b1; m_last = 0; m_prev = 0; m_age = 0;
      end
    end else if (m_mode == 1) begin
      if (press && last_change == 9'h01C) m_last = 1;
      if (press && last_change == 9'h023) m_last = 2;
      if (key_down[9'h01C] && !key_down[9'h023])      d = 1;
      else if (key_down[9'h023] && !key_down[9'h01C]) d = 2;
      else if (key_down[9'h01C])                      d = m_last;
      else                                            d = 0;
      if (slime_die) begin
        m_mode = 2; m_spent = 0;
      end else if (d != 0) begin
        m_age = (d != m_prev) ? 0 : m_age + 1;
        if (m_age % R == 0) e_ks = (d == 1) ? 2'b10 : 2'b01;
      end
      m_prev = d;
    end else begin
      m_spent++;
      if (m_spent == O) m_mode = 0;
    end
    e_gs = 2'(m_mode);
    e_rg = (m_mode != 1);
  endtask

  task automatic compare();
    check("game_state", 32'(game_state), 32'(e_gs));
    check("start_pulse", 32'(start_pulse), 32'(e_start));
    check("key_state", 32'(key_state), 32'(e_ks));
    check("rst_game", 32'(rst_game), 32'(e_rg));
  endtask

  // One clock: check outputs at the falling edge, then drive the next inputs.
  task automatic cycle(input logic kv, input logic [8:0] lc, input logic down, input logic sd);
    @(negedge clk);
    compare();
    if (kv) key_down[lc] = down;
    key_valid   = kv;
    last_change = lc;
    slime_die   = sd;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 9'h000, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1 model_reset();
    compare();
    @(negedge clk);
    rst = 1'b1;
    key_valid = 1'b0; slime_die = 1'b0; last_change = 9'h000;
    model_step();
  endtask

  int cnt;

  initial begin
    rst = 1'b0; key_valid = 1'b0; last_change = 9'h000; key_down = '0; slime_die = 1'b0;
    model_reset();
    #12 compare();
    @(negedge clk);
    rst = 1'b1;
    model_step();

    // Idle after reset: stays in COVER.
    idle(100);

    // Extended Enter starts the game.
    cycle(1'b1, 9'h15A, 1'b1, 1'b0);
    cycle(1'b0, 9'h000, 1'b0, 1'b0);
    check("enter_to_play", 32'(game_state), 32'd1);
    check("enter_start", 32'(start_pulse), 32'd1);
    cycle(1'b1, 9'h15A, 1'b0, 1'b0);
    check("start_one_cycle", 32'(start_pulse), 32'd0);

    // Hold A for 20 cycles: pulses at +1, +9, +17.
    cnt = 0;
    cycle(1'b1, 9'h01C, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 9'h000, 1'b0, 1'b0);
      if (key_state == 2'b10) cnt++;
    end
    cycle(1'b1, 9'h01C, 1'b0, 1'b0);
    if (key_state == 2'b10) cnt++;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 9'h000, 1'b0, 1'b0);
      if (key_state != 2'b00) cnt++;
    end
    check("a_hold_pulses", 32'(cnt), 32'd3);

    // A held, D pressed then released.
    cycle(1'b1, 9'h01C, 1'b1, 1'b0);
    idle(3);
    cycle(1'b1, 9'h023, 1'b1, 1'b0);
    cycle(1'b0, 9'h000, 1'b0, 1'b0);
    check("d_over_a", 32'(key_state), 32'b01);
    idle(2);
    cycle(1'b1, 9'h023, 1'b0, 1'b0);
    cycle(1'b0, 9'h000, 1'b0, 1'b0);
    check("back_to_a", 32'(key_state), 32'b10);
    cycle(1'b1, 9'h01C, 1'b0, 1'b0);

    // Death, ignored Enter during OVER, timed return to COVER.
    cycle(1'b0, 9'h000, 1'b0, 1'b1);
    cycle(1'b0, 9'h000, 1'b0, 1'b0);
    check("die_to_over", 32'(game_state), 32'd2);
    cnt = 1;
    cycle(1'b1, 9'h05A, 1'b1, 1'b0);
    if (game_state == 2'd2) cnt++;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 9'h000, 1'b0, 1'b0);
      if (game_state == 2'd2) cnt++;
    end
    check("over_len", 32'(cnt), 32'(O));
    cycle(1'b1, 9'h05A, 1'b0, 1'b0);

    // Re-enter PLAY, die, reset asynchronously mid-OVER.
    cycle(1'b1, 9'h05A, 1'b1, 1'b0);
    cycle(1'b1, 9'h05A, 1'b0, 1'b0);
    idle(2);
    cycle(1'b0, 9'h000, 1'b0, 1'b1);
    idle(3);
    async_reset();
    idle(15);
    check("cover_after_reset", 32'(game_state), 32'd0);

    // Random traffic on Enter, A, D, an unrelated key and slime_die.
    for (int i = 0; i < 4000; i++) begin
      int          r;
      logic [8:0]  code;
      r = $urandom_range(0, 99);
      if (r < 6)       code = ($urandom_range(0, 1) == 0) ? 9'h05A : 9'h15A;
      else if (r < 22) code = ($urandom_range(0, 1) == 0) ? 9'h01C : 9'h023;
      else if (r < 26) code = 9'h029;
      else             code = 9'h000;
      if (code != 9'h000)
        cycle(1'b1, code, ~key_down[code], ($urandom_range(0, 99) < 2));
      else
        cycle(1'b0, 9'h000, 1'b0, ($urandom_range(0, 99) < 2));
      if ($urandom_range(0, 499) == 0) async_reset();
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
